// File: rtl/uart_tx_rr_arbiter_if.sv
// Byte-producer handshake bundle for the shared UART TX arbiter.
// The producers drive valid/data; the arbiter answers with a one-hot ready strobe.
interface uart_tx_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART TX line among NUM_REQ byte producers.
// One requester is granted per frame, and arbitration only happens while the line is idle.
module uart_tx_rr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int ID_W         = 2
) (
  input  logic                 clk_100p0,
  input  logic                 rst,
  uart_tx_rr_arbiter_if.slave  bus,
  output logic                 tx_out,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_r, state_n;
  logic [BAUD_W-1:0]  baud_r;
  logic [2:0]         bit_r;
  logic [7:0]         data_r;
  logic               tx_r, tx_n;
  logic               busy_r;
  logic [ID_W-1:0]    grant_r;
  logic [ID_W-1:0]    last_r;

  logic               any_s, hi_any_s, term_s;
  logic [ID_W-1:0]    hi_sel_s, lo_sel_s, sel_s;
  logic [NUM_REQ-1:0] onehot_s, ready_s;
  logic [7:0]         byte_s;

  assign term_s = (baud_r == BAUD_W'(CLKS_PER_BIT - 1));

  // Round-robin pick: lowest valid index above last, else lowest valid index overall (wrap)
  always_comb begin
    hi_any_s = 1'b0;
    hi_sel_s = '0;
    lo_sel_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      hi_any_s = hi_any_s | (bus.req_valid[i] && (ID_W'(i) > last_r));
      hi_sel_s = (bus.req_valid[i] && (ID_W'(i) > last_r)) ? ID_W'(i) : hi_sel_s;
      lo_sel_s = bus.req_valid[i] ? ID_W'(i) : lo_sel_s;
    end
    any_s    = |bus.req_valid;
    sel_s    = hi_any_s ? hi_sel_s : lo_sel_s;
    onehot_s = '0;
    byte_s   = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      onehot_s[i] = (ID_W'(i) == sel_s) && any_s;
      byte_s      = (ID_W'(i) == sel_s) ? bus.req_data[8*i +: 8] : byte_s;
    end
  end

  // State register
  always_ff @(posedge clk_100p0) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic: each line phase ends on the baud terminal count
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE:  state_n = any_s ? S_START : S_IDLE;
      S_START: state_n = term_s ? S_DATA : S_START;
      S_DATA:  state_n = (term_s && (bit_r == 3'd7)) ? S_STOP : S_DATA;
      S_STOP:  state_n = term_s ? S_IDLE : S_STOP;
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic: ready strobe and the next value of the registered TX line
  always_comb begin
    ready_s = '0;
    tx_n    = tx_r;
    case (state_r)
      S_IDLE: begin
        if (!rst && any_s) begin
          ready_s = onehot_s;
          tx_n    = 1'b0;
        end else begin
          ready_s = '0;
          tx_n    = 1'b1;
        end
      end
      S_START: tx_n = term_s ? data_r[0] : 1'b0;
      S_DATA: begin
        if (term_s) begin
          tx_n = (bit_r == 3'd7) ? 1'b1 : data_r[bit_r + 3'd1];
        end else begin
          tx_n = tx_r;
        end
      end
      S_STOP:  tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
  end

  // Datapath: byte latch, baud/bit counters, grant bookkeeping
  always_ff @(posedge clk_100p0) begin
    if (rst) begin
      baud_r  <= '0;
      bit_r   <= 3'd0;
      data_r  <= 8'h00;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      grant_r <= '0;
      last_r  <= ID_W'(NUM_REQ - 1);
    end else begin
      tx_r <= tx_n;
      case (state_r)
        S_IDLE: begin
          baud_r <= '0;
          bit_r  <= 3'd0;
          if (any_s) begin
            data_r  <= byte_s;
            grant_r <= sel_s;
            last_r  <= sel_s;
            busy_r  <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_START: baud_r <= term_s ? '0 : baud_r + BAUD_W'(1);
        S_DATA: begin
          baud_r <= term_s ? '0 : baud_r + BAUD_W'(1);
          if (term_s) begin
            bit_r <= (bit_r == 3'd7) ? 3'd0 : bit_r + 3'd1;
          end else begin
            bit_r <= bit_r;
          end
        end
        S_STOP: begin
          baud_r <= term_s ? '0 : baud_r + BAUD_W'(1);
          busy_r <= term_s ? 1'b0 : 1'b1;
        end
        default: begin
          baud_r <= '0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_s;
  assign tx_out        = tx_r;
  assign busy          = busy_r;
  assign grant_id      = grant_r;

endmodule
